// File: rtl/rv_ram_fifo.sv
// rv_ram_fifo: first-word-fall-through FIFO over a reset-cleared, combinationally-read dual-port RAM.
// Define RV_FIFO_ERR_CHECK_EN to build sticky overflow/underflow flags; otherwise they are tied low.
module rv_ram_fifo #(
   parameter int DATAW     = 32,
   parameter int DEPTH     = 16,
   parameter int ALM_FULL  = DEPTH - 2,
   parameter int ALM_EMPTY = 1,
   parameter int ADDRW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DATAW-1:0] data_in,
   input  logic             pop,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic             alm_empty,
   output logic             alm_full,
   output logic [ADDRW:0]   count,
   output logic             err_ovf,
   output logic             err_udf
);
   localparam logic [ADDRW:0] CNT_FULL = (ADDRW+1)'(DEPTH);
   localparam logic [ADDRW:0] CNT_AF   = (ADDRW+1)'(ALM_FULL);
   localparam logic [ADDRW:0] CNT_AE   = (ADDRW+1)'(ALM_EMPTY);
   logic [DATAW-1:0] ram_q [DEPTH];
   logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, waddr, raddr;
   logic [ADDRW:0]   count_q, count_d;
   logic             empty_q, empty_d, full_q, full_d;
   logic             alm_empty_q, alm_empty_d, alm_full_q, alm_full_d;
   logic             push_ok, pop_ok, wren;
   logic [DATAW-1:0] wdata;
   // Acceptance looks only at registered flags, so push/pop never reach an output combinationally.
   always_comb begin
      push_ok     = push & ~full_q;
      pop_ok      = pop & ~empty_q;
      wren        = push_ok;
      waddr       = wr_ptr_q;
      wdata       = data_in;
      raddr       = rd_ptr_q;
      wr_ptr_d    = push_ok ? wr_ptr_q + ADDRW'(1) : wr_ptr_q;
      rd_ptr_d    = pop_ok ? rd_ptr_q + ADDRW'(1) : rd_ptr_q;
      count_d     = count_q + (ADDRW+1)'(push_ok) - (ADDRW+1)'(pop_ok);
      empty_d     = count_d == '0;
      full_d      = count_d == CNT_FULL;
      alm_empty_d = count_d <= CNT_AE;
      alm_full_d  = count_d >= CNT_AF;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         alm_empty_q <= 1'b1;
         alm_full_q  <= (ALM_FULL == 0);
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         alm_empty_q <= alm_empty_d;
         alm_full_q  <= alm_full_d;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
      end else if (wren) begin
         ram_q[waddr] <= wdata;
      end
   end
   assign data_out  = ram_q[raddr];
   assign empty     = empty_q;
   assign full      = full_q;
   assign alm_empty = alm_empty_q;
   assign alm_full  = alm_full_q;
   assign count     = count_q;
`ifdef RV_FIFO_ERR_CHECK_EN
   logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
   always_comb begin
      err_ovf_d = err_ovf_q | (push & full_q);
      err_udf_d = err_udf_q | (pop & empty_q);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end
   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_rv_ram_fifo.sv
// tb_rv_ram_fifo: scoreboard bench for rv_ram_fifo (DEPTH=16); stimulus queues expected data, a negedge monitor checks the head.
module tb_rv_ram_fifo;
   logic        clk, reset, push, pop;
   logic [31:0] data_in, data_out;
   logic        empty, full, alm_empty, alm_full, err_ovf, err_udf;
   logic [4:0]  count;
   int          vectors = 0, miscompares = 0, mcount = 0;
   bit          movf = 0, mudf = 0;
   logic [31:0] exp_q [$];

   rv_ram_fifo dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
      .data_out(data_out), .empty(empty), .full(full), .alm_empty(alm_empty),
      .alm_full(alm_full), .count(count), .err_ovf(err_ovf), .err_udf(err_udf)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
      end
   endtask

   // FWFT head check: whenever the DUT says non-empty, data_out must equal the oldest queued entry.
   always @(negedge clk) begin
      if (!reset && !empty) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL head: got %0h expected nothing (scoreboard empty)", data_out);
         end else begin
            chk("head", {32'b0, data_out}, {32'b0, exp_q[0]});
            if (pop) void'(exp_q.pop_front());
         end
      end
   end

   task automatic check_state();
      chk("count", {59'b0, count}, 64'(mcount));
      chk("empty", {63'b0, empty}, 64'(mcount == 0));
      chk("full", {63'b0, full}, 64'(mcount == 16));
      chk("alm_empty", {63'b0, alm_empty}, 64'(mcount <= 1));
      chk("alm_full", {63'b0, alm_full}, 64'(mcount >= 14));
      chk("err_ovf", {63'b0, err_ovf}, {63'b0, movf});
      chk("err_udf", {63'b0, err_udf}, {63'b0, mudf});
   endtask

   task automatic cyc(input logic p, input logic [31:0] d, input logic q);
      bit pok, qok;
      push = p;
      data_in = d;
      pop = q;
      @(posedge clk);
      #1;
      pok = p && mcount < 16;
      qok = q && mcount > 0;
`ifdef RV_FIFO_ERR_CHECK_EN
      if (p && mcount == 16) movf = 1;
      if (q && mcount == 0) mudf = 1;
`endif
      if (pok) exp_q.push_back(d);
      mcount = mcount + int'(pok) - int'(qok);
      push = 0;
      pop = 0;
      check_state();
   endtask

   task automatic do_reset();
      reset = 1;
      push = 0;
      pop = 0;
      @(posedge clk);
      #1;
      reset = 0;
      mcount = 0;
      movf = 0;
      mudf = 0;
      exp_q.delete();
      check_state();
      chk("reset_data", {32'b0, data_out}, 64'h0);
   endtask

   initial begin
      push = 0;
      pop = 0;
      data_in = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      do_reset();
      for (int k = 0; k < 16; k++) cyc(1, 32'h100 + k, 0);
      for (int k = 0; k < 16; k++) cyc(0, 0, 1);
      cyc(0, 0, 1);
      cyc(1, 32'hBEEF, 1);
      chk("beef", {32'b0, data_out}, 64'hBEEF);
      for (int k = 0; k < 15; k++) cyc(1, 32'h300 + k, 0);
      cyc(1, 32'hBAD, 0);
      cyc(1, 32'hDEAD, 1);
      for (int k = 0; k < 15; k++) cyc(0, 0, 1);
      for (int k = 0; k < 5; k++) cyc(1, 32'h400 + k, 0);
      for (int k = 0; k < 40; k++) cyc(1, 32'h500 + k, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 1);
      for (int k = 0; k < 9; k++) cyc(1, 32'h600 + k, 0);
      do_reset();
      cyc(1, 32'h55, 0);
      chk("after_reset", {32'b0, data_out}, 64'h55);
      cyc(0, 0, 1);
      repeat (2) @(posedge clk);
      chk("drained", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/rv_ram_fifo.md
# rv_ram_fifo

Synchronous first-word-fall-through FIFO built on the team's dual-port RAM (instantiated with `BYTEENW=1`, `OUT_REG=0`). It sits directly upstream of the RAM: it owns write/read pointers, occupancy and flags, and drives `wren`/`waddr`/`wdata`/`raddr`. Pipeline stages use it to decouple producers from consumers, for example an issue queue between decode and dispatch.

## Interface
- `DATAW`, 32, entry width in bits.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `ALM_FULL`, DEPTH-2, `alm_full` asserts when count ≥ `ALM_FULL`; range 1..DEPTH-1.
- `ALM_EMPTY`, 1, `alm_empty` asserts when count ≤ `ALM_EMPTY`; range 0..DEPTH-1.
- `ADDRW`, $clog2(DEPTH), pointer width (derived).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request.
- data_in  in  DATAW  write data, sampled when a push is accepted.
- pop  in  1  read request; consumes the head entry.
- data_out  out  DATAW  head entry (FWFT); valid while `empty`=0.
- empty  out  1  registered; count==0.
- full  out  1  registered; count==DEPTH.
- alm_empty  out  1  registered; count ≤ ALM_EMPTY.
- alm_full  out  1  registered; count ≥ ALM_FULL.
- count  out  ADDRW+1  registered occupancy, 0..DEPTH.
- err_ovf  out  1  sticky overflow flag (see Configuration).
- err_udf  out  1  sticky underflow flag (see Configuration).

## Operation
- Push acceptance: `push_ok = push & ~full`. Pop acceptance: `pop_ok = pop & ~empty`. Acceptance uses only the registered flags, never the same-cycle opposite request.
- On `push_ok`: RAM write at `wr_ptr`; `wr_ptr` increments mod DEPTH (natural ADDRW-bit wrap).
- On `pop_ok`: `rd_ptr` increments mod DEPTH.
- `raddr` = `rd_ptr`; `data_out` = RAM combinational read of `rd_ptr`.
- Count update: +1 on push_ok only, −1 on pop_ok only, unchanged on both or neither.
- Flags are computed from the next count and registered, so they are exact in the cycle after each update.
- Boundaries:
  - Push while full: ignored, even with a simultaneous pop. The pop is accepted and the count becomes DEPTH-1.
  - Pop while empty: ignored, even with a simultaneous push. The push is accepted and the count becomes 1.
  - Push and pop together at 0 < count < DEPTH: both accepted, count unchanged, pointers each advance.
  - Pointer wrap from DEPTH-1 to 0 causes no flag glitch.
- Reset mid-operation discards all contents: pointers, count and flags return to their reset values, and the RAM is cleared by its own reset.
- Reset values: `count`=0, `empty`=1, `full`=0, `alm_empty`=1, `alm_full`=(ALM_FULL==0 ? 1 : 0), i.e. 0 for legal values, `err_ovf`=`err_udf`=0, `data_out`=0 (RAM cleared).

## Timing
- Write-to-read latency is 1 cycle. A push accepted at edge N makes `empty`=0 and the data visible on `data_out` after edge N.
- A pop accepted at edge N presents the next entry on `data_out` after edge N. There is no read bubble.
- Flag and count latency is 1 edge after the accepting event.
- `data_out` is don't-care while `empty`=1.
- The block is fully synchronous; there is no combinational path from `push`/`pop` to any output.

## Configuration
- `RV_FIFO_ERR_CHECK_EN` defined:
  - `err_ovf` sets on the edge where `push & full`.
  - `err_udf` sets on the edge where `pop & empty`.
  - Both flags are sticky until reset.
- `RV_FIFO_ERR_CHECK_EN` not defined: `err_ovf` and `err_udf` are tied to 0 and no error logic is synthesized.
- FIFO data behaviour is identical in both builds.

## Test plan
- **Reset then fill:** DEPTH=16. Reset, then push 0x100..0x10F on 16 consecutive cycles. Expect `full`=1 and `count`=16 after the 16th edge, and `alm_full`=1 from `count`=14.
- **Drain:** pop 16 times from the full FIFO. Expect `data_out` sequence 0x100..0x10F, then `empty`=1 and `count`=0. `alm_empty`=1 at `count`≤1.
- **Simultaneous push and pop:** at `count`=5, assert both for 40 cycles. Expect `count` to stay 5, data order preserved, and pointers wrapping at least twice.
- **Full/empty edge cases:**
  - At full, push 0xDEAD together with pop. Expect `count`=15 and 0xDEAD never seen.
  - At empty, pop together with push of 0xBEEF. Expect `count`=1 and `data_out`=0xBEEF.
- **Error flags (macro defined):**
  - Push when full: expect `err_ovf`=1, holding until reset.
  - Pop when empty: expect `err_udf`=1.
  - Without the macro: both flags stay 0.
- **Reset mid-operation:** at `count`=9, assert reset for 1 cycle. Expect `count`=0, `empty`=1, `data_out`=0. A push of 0x55 is then read back first.
